// File: rtl/sha3_scan_pkg.sv
// Shared types and constants for the scan job sequencer and its result serializer.
package sha3_scan_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StRun,
        StEmit,
        StAdvance
    } state_t;

    localparam int unsigned RESULT_WORDS = 52;
    localparam int unsigned HASH_LANES   = 25;
    localparam logic [4:0]  ADDR_THR_LO  = 5'd24;
    localparam logic [4:0]  ADDR_THR_HI  = 5'd25;

    function automatic int unsigned nonce_index(input bit proper);
        return proper ? 19 : 21;
    endfunction

    function automatic int unsigned template_words(input bit proper);
        return proper ? 20 : 24;
    endfunction

endpackage

// File: rtl/sha3_result_serializer.sv
// Emits the 52-word result packet (found flag, absolute nonce, 25 hash lanes) over valid/ready.
module sha3_result_serializer
    import sha3_scan_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     found,
    input  logic [31:0]              abs_nonce,
    input  logic [64*HASH_LANES-1:0] hash,
    output logic                     res_valid,
    output logic [31:0]              res_data,
    output logic                     res_last,
    input  logic                     res_ready,
    output logic                     done
);

    localparam logic [5:0] LastIdx = 6'(RESULT_WORDS - 1);

    logic [5:0] idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            idx_q     <= '0;
        end else if (start) begin
            res_valid <= 1'b1;
            idx_q     <= '0;
        end else if (res_valid && res_ready) begin
            if (idx_q == LastIdx) begin
                res_valid <= 1'b0;
            end else begin
                idx_q <= idx_q + 6'd1;
            end
        end
    end

    // Data is a pure function of the held index and captured result, so it stays put on stalls.
    always_comb begin
        res_data = '0;
        if (idx_q == 6'd0) begin
            res_data = {31'b0, found};
        end else if (idx_q == 6'd1) begin
            res_data = abs_nonce;
        end else if (found) begin
            for (int unsigned w = 0; w < 2 * HASH_LANES; w++) begin
                if (idx_q == 6'(w + 2)) begin
                    res_data = hash[32*w +: 32];
                end
            end
        end
    end

    assign res_last = res_valid && (idx_q == LastIdx);
    assign done     = res_valid && res_ready && res_last;

endmodule

// File: rtl/sha3_scan_job_sequencer.sv
// Scan job sequencer: holds template/threshold, launches scans, streams results, auto-advances nonce.
module sha3_scan_job_sequencer
    import sha3_scan_pkg::*;
#(
    parameter bit PROPER = 1'b1,
    localparam int unsigned WORDS = template_words(PROPER)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_wr,
    input  logic [4:0]               cfg_addr,
    input  logic [31:0]              cfg_data,
    input  logic                     cmd_go,
    input  logic                     cmd_auto,
    input  logic                     cmd_stop,
    output logic                     busy,
    output logic                     scan_start,
    output logic [63:0]              scan_threshold,
    output logic [32*WORDS-1:0]      scan_template,
    input  logic                     scan_ready,
    input  logic                     scan_found,
    input  logic [31:0]              scan_nonce,
    input  logic [64*HASH_LANES-1:0] scan_hash,
    input  logic [31:0]              scan_count,
    output logic                     res_valid,
    output logic [31:0]              res_data,
    output logic                     res_last,
    input  logic                     res_ready,
    output logic [31:0]              jobs_done
);

    localparam int unsigned NIDX = nonce_index(PROPER);

    state_t                   state;
    logic                     auto_q;
    logic                     seen_low_q;
    logic                     found_q;
    logic [31:0]              base_q;
    logic [31:0]              abs_q;
    logic [64*HASH_LANES-1:0] hash_q;
    logic [31:0]              next_nonce;
    logic                     capture;
    logic                     emit_done;

    assign busy = (state != StIdle);

    // seen_low guards against a scanner still finishing a job from before a reset.
    assign capture    = (state == StRun) && seen_low_q && scan_ready;
    assign next_nonce = found_q ? abs_q + 32'd1 : base_q + scan_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            auto_q         <= 1'b0;
            seen_low_q     <= 1'b0;
            found_q        <= 1'b0;
            base_q         <= '0;
            abs_q          <= '0;
            hash_q         <= '0;
            scan_start     <= 1'b0;
            scan_threshold <= '0;
            scan_template  <= '0;
            jobs_done      <= '0;
        end else begin
            scan_start <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cfg_wr) begin
                        for (int unsigned i = 0; i < WORDS; i++) begin
                            if (cfg_addr == 5'(i)) begin
                                scan_template[32*i +: 32] <= cfg_data;
                            end
                        end
                        if (cfg_addr == ADDR_THR_LO) scan_threshold[31:0] <= cfg_data;
                        if (cfg_addr == ADDR_THR_HI) scan_threshold[63:32] <= cfg_data;
                    end
                    if (cmd_go) begin
                        auto_q <= cmd_auto;
                        base_q <= scan_template[32*NIDX +: 32];
                        state  <= StLaunch;
                    end
                end
                StLaunch: begin
                    if (scan_ready) begin
                        scan_start <= 1'b1;
                        seen_low_q <= 1'b0;
                        state      <= StRun;
                    end
                end
                StRun: begin
                    if (!scan_ready) seen_low_q <= 1'b1;
                    if (capture) begin
                        found_q <= scan_found;
                        abs_q   <= scan_found ? base_q + scan_nonce : base_q;
                        hash_q  <= scan_hash;
                        state   <= StEmit;
                    end
                end
                StEmit: begin
                    if (emit_done) begin
                        jobs_done <= jobs_done + 32'd1;
                        state     <= auto_q ? StAdvance : StIdle;
                    end
                end
                StAdvance: begin
                    scan_template[32*NIDX +: 32] <= next_nonce;
                    base_q                       <= next_nonce;
                    state                        <= auto_q ? StLaunch : StIdle;
                end
                default: state <= StIdle;
            endcase
            if (cmd_stop) auto_q <= 1'b0;
        end
    end

    sha3_result_serializer u_serializer (
        .clk       (clk),
        .rst       (rst),
        .start     (capture),
        .found     (found_q),
        .abs_nonce (abs_q),
        .hash      (hash_q),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_last  (res_last),
        .res_ready (res_ready),
        .done      (emit_done)
    );

endmodule

// File: tb/tb_sha3_scan_job_sequencer.sv
// Randomized scoreboard bench: scanner model pushes expected packets, a monitor pops and compares.
module tb_sha3_scan_job_sequencer;
    import sha3_scan_pkg::*;

    localparam int NIDX = 19;

    logic          clk;
    logic          rst;
    logic          cfg_wr, cmd_go, cmd_auto, cmd_stop;
    logic [4:0]    cfg_addr;
    logic [31:0]   cfg_data;
    logic          busy, scan_start, scan_ready, scan_found;
    logic [63:0]   scan_threshold;
    logic [639:0]  scan_template;
    logic [31:0]   scan_nonce, scan_count, res_data, jobs_done;
    logic [1599:0] scan_hash;
    logic          res_valid, res_last, res_ready;

    logic          cfg0_wr;
    logic [4:0]    cfg0_addr;
    logic [31:0]   cfg0_data;
    logic          busy0, start0, rv0, rl0;
    logic [63:0]   thr0;
    logic [767:0]  tpl0;
    logic [31:0]   rd0, jd0;

    int vectors = 0;
    int miscompares = 0;
    int starts = 0;
    int exp_jobs = 0;
    logic [32:0] exp_q[$];

    logic [31:0] tmpl[24];
    logic [63:0] thr;
    logic [31:0] model_base;
    bit          model_auto;
    bit          abandon;
    bit          sc_rand;
    bit          sc_found;
    logic [31:0] sc_nonce;
    int          sc_lat;
    int          rr_mode;

    sha3_scan_job_sequencer #(.PROPER(1'b1)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cmd_go(cmd_go), .cmd_auto(cmd_auto), .cmd_stop(cmd_stop), .busy(busy),
        .scan_start(scan_start), .scan_threshold(scan_threshold), .scan_template(scan_template),
        .scan_ready(scan_ready), .scan_found(scan_found), .scan_nonce(scan_nonce),
        .scan_hash(scan_hash), .scan_count(scan_count), .res_valid(res_valid),
        .res_data(res_data), .res_last(res_last), .res_ready(res_ready), .jobs_done(jobs_done)
    );

    sha3_scan_job_sequencer #(.PROPER(1'b0)) dut0 (
        .clk(clk), .rst(rst), .cfg_wr(cfg0_wr), .cfg_addr(cfg0_addr), .cfg_data(cfg0_data),
        .cmd_go(1'b0), .cmd_auto(1'b0), .cmd_stop(1'b0), .busy(busy0),
        .scan_start(start0), .scan_threshold(thr0), .scan_template(tpl0),
        .scan_ready(scan_ready), .scan_found(scan_found), .scan_nonce(scan_nonce),
        .scan_hash(scan_hash), .scan_count(scan_count), .res_valid(rv0),
        .res_data(rd0), .res_last(rl0), .res_ready(1'b0), .jobs_done(jd0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] tword(input int i);
        return scan_template[32*i +: 32];
    endfunction

    function automatic void model_write(input logic [4:0] a, input logic [31:0] d);
        if (a < 5'd20) tmpl[a] = d;
        else if (a == 5'd24) thr[31:0] = d;
        else if (a == 5'd25) thr[63:32] = d;
    endfunction

    // Scanner model: on each start pulse, goes not-ready for a while, then posts a result.
    initial begin
        logic [31:0] absn, nb;
        int lat;
        scan_ready = 1'b1; scan_found = 1'b0; scan_nonce = '0; scan_hash = '0;
        forever begin
            @(posedge clk); #1;
            if (scan_start) begin
                chk("launch_nonce_word", {32'b0, tword(NIDX)}, {32'b0, tmpl[NIDX]});
                scan_ready = 1'b0;
                lat = sc_rand ? int'($urandom_range(3, 8)) : sc_lat;
                repeat (lat) @(posedge clk);
                #1;
                scan_found = sc_rand ? 1'($urandom_range(0, 1)) : sc_found;
                scan_nonce = sc_rand ? $urandom : sc_nonce;
                for (int w = 0; w < 50; w++) scan_hash[32*w +: 32] = $urandom;
                if (abandon) begin
                    abandon = 1'b0;
                end else begin
                    absn = scan_found ? model_base + scan_nonce : model_base;
                    exp_q.push_back({1'b0, 31'b0, scan_found});
                    exp_q.push_back({1'b0, absn});
                    for (int w = 0; w < 50; w++)
                        exp_q.push_back({w == 49, scan_found ? scan_hash[32*w +: 32] : 32'h0});
                    if (model_auto) begin
                        nb = scan_found ? absn + 32'd1 : model_base + scan_count;
                        model_base = nb;
                        tmpl[NIDX] = nb;
                    end
                end
                scan_ready = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (scan_start) starts++;
        end
    end

    initial begin
        logic [3:0] pat;
        int pi;
        pat = 4'b1001;
        pi = 0;
        res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                1:       res_ready = 1'($urandom_range(0, 1));
                2: begin res_ready = pat[3 - pi]; pi = (pi + 1) % 4; end
                default: res_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops one expected word per accepted transfer and checks stall stability.
    initial begin
        logic [32:0] e;
        logic [31:0] held_d;
        bit held_v, jobs_chk;
        held_v = 0; jobs_chk = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 0; jobs_chk = 0;
            end else begin
                if (jobs_chk) begin
                    chk("jobs_done", {32'b0, jobs_done}, exp_jobs);
                    jobs_chk = 0;
                end
                if (res_valid) begin
                    if (held_v) chk("stall_stable", {32'b0, res_data}, {32'b0, held_d});
                    if (res_ready) begin
                        held_v = 0;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_word", {31'b0, res_last, res_data}, 64'hDEAD);
                        end else begin
                            e = exp_q.pop_front();
                            chk("res_word", {31'b0, res_last, res_data}, {31'b0, e});
                            if (e[32]) begin exp_jobs++; jobs_chk = 1; end
                        end
                    end else begin
                        held_v = 1; held_d = res_data;
                    end
                end
            end
        end
    end

    task automatic cfg(input logic [4:0] a, input logic [31:0] d, input bit upd);
        @(posedge clk); #1;
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        if (upd) model_write(a, d);
        @(posedge clk); #1;
        cfg_wr = 1'b0;
    endtask

    task automatic job(input bit auto_m, input bit wr, input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        model_base = tmpl[NIDX];
        model_auto = auto_m;
        cmd_go = 1'b1; cmd_auto = auto_m;
        if (wr) begin
            cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
            model_write(a, d);
        end
        @(posedge clk); #1;
        cmd_go = 1'b0; cmd_auto = 1'b0; cfg_wr = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("job_timeout", {63'b0, n >= budget}, 64'd0);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n;
        n = 0;
        while (starts < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("start_timeout", {63'b0, n >= budget}, 64'd0);
    endtask

    task automatic check_reset_state();
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_scan_start", {63'b0, scan_start}, 64'd0);
        chk("rst_res_valid", {62'b0, res_valid, res_last}, 64'd0);
        chk("rst_jobs_done", {32'b0, jobs_done}, 64'd0);
        chk("rst_threshold", scan_threshold, 64'd0);
        chk("rst_template", {63'b0, |scan_template}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        rst = 1'b1; cfg_wr = 0; cfg_addr = '0; cfg_data = '0;
        cmd_go = 0; cmd_auto = 0; cmd_stop = 0; scan_count = 32'd1000;
        cfg0_wr = 0; cfg0_addr = '0; cfg0_data = '0;
        for (int i = 0; i < 24; i++) tmpl[i] = '0;
        thr = '0; model_base = '0; model_auto = 0; abandon = 0;
        sc_rand = 0; sc_found = 0; sc_nonce = '0; sc_lat = 4; rr_mode = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state();

        // Found at nonce 5 with base 19.
        for (int i = 0; i < 20; i++) cfg(5'(i), 32'(i), 1);
        cfg(5'd24, 32'hFFFF_FFFF, 1);
        cfg(5'd25, 32'hFFFF_FFFF, 1);
        @(negedge clk);
        chk("tmpl_word19", {32'b0, tword(19)}, 64'd19);
        chk("threshold", scan_threshold, 64'hFFFF_FFFF_FFFF_FFFF);
        s0 = starts;
        sc_found = 1; sc_nonce = 32'd5; sc_lat = 4;
        job(0, 0, '0, '0);
        wait_idle(400);
        chk("starts_found", starts - s0, 64'd1);

        // Miss in auto mode with nonce wrap, stopped during the second scan.
        cfg(5'd19, 32'hFFFF_FFF0, 1);
        scan_count = 32'h2000_0000;
        sc_found = 0; sc_lat = 6;
        s0 = starts;
        job(1, 0, '0, '0);
        wait_starts(s0 + 2, 400);
        @(posedge clk); #1;
        cmd_stop = 1'b1; model_auto = 0;
        @(posedge clk); #1;
        cmd_stop = 1'b0;
        wait_idle(400);
        chk("auto_starts", starts - s0, 64'd2);
        chk("auto_wrap_word19", {32'b0, tword(19)}, 64'h1FFF_FFF0);

        // Stall pattern 1,0,0,1 on a found result.
        rr_mode = 2; sc_found = 1; sc_nonce = $urandom;
        job(0, 0, '0, '0);
        wait_idle(600);
        rr_mode = 0;

        // Writes and go while busy are ignored.
        s0 = starts; sc_lat = 12;
        job(0, 0, '0, '0);
        wait_starts(s0 + 1, 100);
        @(posedge clk); #1;
        cfg_wr = 1'b1; cfg_addr = 5'd0; cfg_data = 32'hDEAD_BEEF; cmd_go = 1'b1;
        @(posedge clk); #1;
        cfg_addr = 5'd24;
        @(posedge clk); #1;
        cfg_wr = 1'b0; cmd_go = 1'b0;
        wait_idle(400);
        chk("busy_tmpl0", {32'b0, tword(0)}, {32'b0, tmpl[0]});
        chk("busy_threshold", scan_threshold, thr);
        chk("busy_starts", starts - s0, 64'd1);

        // Randomized jobs with idle config traffic and go colliding with a nonce write.
        sc_rand = 1; rr_mode = 1;
        for (int it = 0; it < 8; it++) begin
            cfg(5'($urandom_range(0, 31)), $urandom, 1);
            cfg(5'($urandom_range(19, 25)), $urandom, 1);
            job(0, it % 2 == 1, 5'(NIDX), $urandom);
            wait_idle(800);
            chk("rand_threshold", scan_threshold, thr);
        end
        for (int i = 0; i < 20; i++) chk("final_tmpl", {32'b0, tword(i)}, {32'b0, tmpl[i]});
        rr_mode = 0;

        // Reset while the scanner is mid-dispatch; the next job must wait for it.
        sc_rand = 0; sc_lat = 30; sc_found = 1; sc_nonce = 32'd7;
        job(0, 0, '0, '0);
        wait_starts(starts + 1, 100);
        repeat (4) @(posedge clk);
        #1 abandon = 1; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 24; i++) tmpl[i] = '0;
        thr = '0; exp_jobs = 0;
        @(negedge clk);
        check_reset_state();
        chk("rst_queue_empty", exp_q.size(), 64'd0);
        s0 = starts; sc_lat = 5;
        job(0, 0, '0, '0);
        repeat (3) @(negedge clk);
        chk("launch_waits_busy", {63'b0, busy}, 64'd1);
        chk("launch_waits_nostart", starts - s0, 64'd0);
        wait_idle(600);
        chk("post_rst_starts", starts - s0, 64'd1);
        chk("post_rst_jobs", {32'b0, jobs_done}, 64'd1);

        // Alternate layout: 24 words, nonce in word 21, address 26 ignored.
        @(posedge clk); #1;
        cfg0_wr = 1; cfg0_addr = 5'd21; cfg0_data = 32'h1234_5678;
        @(posedge clk); #1; cfg0_addr = 5'd22; cfg0_data = 32'hAAAA_0022;
        @(posedge clk); #1; cfg0_addr = 5'd23; cfg0_data = 32'hBBBB_0023;
        @(posedge clk); #1; cfg0_addr = 5'd26; cfg0_data = 32'hCCCC_0026;
        @(posedge clk); #1; cfg0_wr = 0;
        @(negedge clk);
        chk("p0_word21", {32'b0, tpl0[32*21 +: 32]}, 64'h1234_5678);
        chk("p0_word22", {32'b0, tpl0[32*22 +: 32]}, 64'hAAAA_0022);
        chk("p0_word23", {32'b0, tpl0[32*23 +: 32]}, 64'hBBBB_0023);
        chk("p0_word20", {32'b0, tpl0[32*20 +: 32]}, 64'd0);
        chk("p0_threshold", thr0, 64'd0);
        chk("p0_busy", {63'b0, busy0}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
